// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared helpers for round-robin arbiters.
//   rr_pick       : rotating-priority one-hot grant over a request vector
//   onehot_to_idx : binary index of a one-hot vector
// Helpers operate on MAX_N_IN-wide vectors; callers zero-extend narrower
// request vectors and slice the result back down.
// Optional feature macro used by users of this package: RR_ARB_MUX_LOCK_EN.
// ---------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int MAX_N_IN  = 16;
  localparam int MAX_SEL_W = 4;

  // Search valid starting at ptr, ascending, wrapping at n; first hit wins.
  function automatic logic [MAX_N_IN-1:0] rr_pick(input logic [MAX_N_IN-1:0] valid,
                                                  input int ptr,
                                                  input int n);
    logic [MAX_N_IN-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N_IN; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && valid[idx[MAX_SEL_W-1:0]]) begin
        g[idx[MAX_SEL_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_N_IN-1:0] oh);
    logic [MAX_SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N_IN; i++) begin
      if (oh[i]) idx = idx | MAX_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// ---------------------------------------------------------------------------
// rr_arb_core
// Round-robin priority pointer plus combinational grant logic.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (ptr -> 0)
//   req         : per-channel requests
//   accept      : the granted request is consumed this cycle
//   lock        : keep the winner at top priority for the next beat
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : binary index of the granted channel
// Optional feature macro for the enclosing design: RR_ARB_MUX_LOCK_EN
// (drives lock; tie lock to 0 for pure round-robin).
// ---------------------------------------------------------------------------
module rr_arb_core
  import rr_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             accept,
  input  logic             lock,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [MAX_N_IN-1:0]  grant_ext;
  logic [MAX_SEL_W-1:0] idx_ext;

  assign grant_ext = rr_pick(MAX_N_IN'(req), int'(ptr_q), N_IN);
  assign grant     = grant_ext[N_IN-1:0];
  assign idx_ext   = onehot_to_idx(grant_ext);
  assign grant_idx = idx_ext[SEL_W-1:0];

  // Upper bits of the package-width helpers are structurally zero.
  generate
    if (N_IN < MAX_N_IN) begin : g_grant_hi
      logic unused_grant_hi;
      assign unused_grant_hi = |grant_ext[MAX_N_IN-1:N_IN];
    end
    if (SEL_W < MAX_SEL_W) begin : g_idx_hi
      logic unused_idx_hi;
      assign unused_idx_hi = |idx_ext[MAX_SEL_W-1:SEL_W];
    end
  endgenerate

  // A locked winner keeps top priority; otherwise priority moves past it.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && |req) begin
      if (lock)                                ptr_d = grant_idx;
      else if (grant_idx == SEL_W'(N_IN - 1))  ptr_d = '0;
      else                                     ptr_d = grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
// N_IN-to-1 round-robin selector with a registered valid/ready output stage.
// Sustains one transfer per cycle while out_ready is held high.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel request
//   in_lock    : (RR_ARB_MUX_LOCK_EN only) hold priority for a burst
//   in_ready   : per-channel accept, one-hot or zero
//   out_data   : registered selected data
//   out_sel    : registered index of the supplying channel
//   out_valid  : output register holds a transfer
//   out_ready  : sink accepts the transfer
// Macro RR_ARB_MUX_LOCK_EN adds in_lock; undefined gives pure round-robin.
// out_ready -> in_ready is a combinational path; out_data/out_valid are not.
// ---------------------------------------------------------------------------
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N_IN-1:0]       in_lock,
`endif
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic              load_en;
  logic              accept;
  logic              any_req;
  logic              win_lock;
  logic [N_IN-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_data;

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;

  assign load_en = !out_valid_q || out_ready;
  assign any_req = |in_valid;
  // Nothing is accepted while reset is asserted.
  assign accept  = load_en && !rst;

`ifdef RR_ARB_MUX_LOCK_EN
  assign win_lock = |(grant & in_lock);
`else
  assign win_lock = 1'b0;
`endif

  rr_arb_core #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .accept    (accept),
    .lock      (win_lock),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready = accept ? grant : '0;

  // AND-OR mux over the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on accept, empty on drain, hold on stall.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load_en) begin
      if (any_req) begin
        out_data_d  = sel_data;
        out_sel_d   = grant_idx;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
// Bench for rr_arb_mux: a 4x32 instance and a 3x5 instance on one clock.
// Define RR_ARB_MUX_LOCK_EN for both bench and RTL to exercise in_lock.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;

  logic         clk;
  logic         rst;

  logic [127:0] d4;
  logic [3:0]   v4;
  logic [3:0]   ir4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic         ov4;
  logic         or4;

  logic [14:0]  d3;
  logic [2:0]   v3;
  logic [2:0]   ir3;
  logic [4:0]   od3;
  logic [1:0]   os3;
  logic         ov3;
  logic         or3;

`ifdef RR_ARB_MUX_LOCK_EN
  logic [3:0]   lk4;
  logic [2:0]   lk3;
`endif

  int n_cmp;
  int n_fail;

  rr_arb_mux #(.WIDTH(32), .N_IN(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d4),
    .in_valid  (v4),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock   (lk4),
`endif
    .in_ready  (ir4),
    .out_data  (od4),
    .out_sel   (os4),
    .out_valid (ov4),
    .out_ready (or4)
  );

  rr_arb_mux #(.WIDTH(5), .N_IN(3)) u3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3),
    .in_valid  (v3),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock   (lk3),
`endif
    .in_ready  (ir3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_valid (ov3),
    .out_ready (or3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lk;
    logic        rdy;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [1:0]  e_os;
    logic [31:0] e_od;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v4  = '0;
    v3  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Apply table rows to the 4-channel instance.
  task automatic run_table(input string tag);
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst = tbl[r].rst;
      v4  = tbl[r].vld;
      or4 = tbl[r].rdy;
`ifdef RR_ARB_MUX_LOCK_EN
      lk4 = tbl[r].lk;
`endif
      #1;
      check($sformatf("%s[%0d].in_ready", tag, r), 32'(ir4), 32'(tbl[r].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].out_valid", tag, r), 32'(ov4), 32'(tbl[r].e_ov));
      check($sformatf("%s[%0d].out_sel", tag, r), 32'(os4), 32'(tbl[r].e_os));
      check($sformatf("%s[%0d].out_data", tag, r), od4, tbl[r].e_od);
    end
    tbl.delete();
  endtask

  // Randomized traffic against a queue-based reference: the queue holds the
  // beat sitting in the output register (at most one).
  task automatic run_rand(input int n, input int cycles);
    int          ptr;
    int          win;
    int          idx;
    int          qs[$];
    logic [31:0] qd[$];
    logic [3:0]  vld;
    logic        rdy;
    logic [31:0] dat[4];
    logic [31:0] mask;
    logic [3:0]  e_ir;
    logic [3:0]  a_ir;
    logic        a_ov;
    logic [1:0]  a_os;
    logic [31:0] a_od;
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'h0000_001F;
    ptr  = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      vld = 4'($urandom_range(0, (1 << n) - 1));
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) dat[i] = $urandom & mask;
      if (n == 4) begin
        v4  = vld;
        or4 = rdy;
        d4  = {dat[3], dat[2], dat[1], dat[0]};
      end else begin
        v3  = vld[2:0];
        or3 = rdy;
        d3  = {dat[2][4:0], dat[1][4:0], dat[0][4:0]};
      end
      #1;
      if (n == 4) begin
        a_ir = ir4; a_ov = ov4; a_os = os4; a_od = od4;
      end else begin
        a_ir = {1'b0, ir3}; a_ov = ov3; a_os = os3; a_od = {27'd0, od3};
      end
      win = -1;
      for (int k = 0; k < n; k++) begin
        idx = (ptr + k) % n;
        if (win < 0 && vld[idx]) win = idx;
      end
      e_ir = '0;
      if ((qs.size() == 0 || rdy) && win >= 0) e_ir[win] = 1'b1;
      check($sformatf("rand%0d[%0d].in_ready", n, c), 32'(a_ir), 32'(e_ir));
      if (qs.size() > 0) begin
        check($sformatf("rand%0d[%0d].out_valid", n, c), 32'(a_ov), 32'd1);
        check($sformatf("rand%0d[%0d].out_sel", n, c), 32'(a_os), 32'(qs[0]));
        check($sformatf("rand%0d[%0d].out_data", n, c), a_od, qd[0]);
        if (rdy) begin
          void'(qs.pop_front());
          void'(qd.pop_front());
        end
      end else begin
        check($sformatf("rand%0d[%0d].out_valid", n, c), 32'(a_ov), 32'd0);
      end
      if (e_ir != '0) begin
        qs.push_back(win);
        qd.push_back(dat[win]);
        ptr = (win + 1) % n;
      end
      @(posedge clk);
    end
    #1;
    check($sformatf("rand%0d.final_pending", n), 32'(n == 4 ? ov4 : ov3), 32'(qs.size()));
    @(negedge clk);
    v4 = '0;
    v3 = '0;
  endtask

  initial begin
    logic [1:0]  e3s[4];
    logic [4:0]  e3d[4];
    logic [2:0]  e3r[4];
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    d4  = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    v4  = '0;
    or4 = 1'b1;
    d3  = {5'h15, 5'h0A, 5'h0F};
    v3  = '0;
    or3 = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    lk4 = '0;
    lk3 = '0;
`endif

    // Reset with all channels requesting, then round-robin rotation.
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 32'hB});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h8, 1'b1, 2'd3, 32'hD});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA});
    // Back-pressure: one beat, 5 stall cycles, release, then drain.
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA});
    for (int s = 0; s < 5; s++)
      tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b1, 2'd0, 32'hA});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 32'hB});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 32'hB});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 32'hB});
    // Sparse / wrap: reach ptr=3, lone ch1 wins, then ch2 ahead of ch0.
    tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 32'hB});
    tbl.push_back('{1'b0, 4'h5, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    run_table("rr4");

`ifdef RR_ARB_MUX_LOCK_EN
    // ch2 locked for three beats, released on the fourth, then 3,0.
    tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'hF, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'hF, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 32'hC});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h8, 1'b1, 2'd3, 32'hD});
    tbl.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA});
    run_table("lock4");
    lk4 = '0;
`endif

    // Non-power-of-two instance: 3 channels of 5 bits.
    e3s = '{2'd0, 2'd1, 2'd2, 2'd0};
    e3d = '{5'h0F, 5'h0A, 5'h15, 5'h0F};
    e3r = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      v3  = 3'b111;
      or3 = 1'b1;
      #1;
      check($sformatf("rr3[%0d].in_ready", b), 32'(ir3), 32'(e3r[b]));
      @(posedge clk);
      #1;
      check($sformatf("rr3[%0d].out_valid", b), 32'(ov3), 32'd1);
      check($sformatf("rr3[%0d].out_sel", b), 32'(os3), 32'(e3s[b]));
      check($sformatf("rr3[%0d].out_data", b), 32'(od3), 32'(e3d[b]));
    end

    run_rand(4, 400);
    run_rand(3, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-to-1 selector with round-robin arbitration and a registered, valid/ready-handshaked output.
- Next generation of the 2-to-1 datapath select mux.
- Used where several RV32 sources contend for one sink, e.g. instruction fetch, data load and debug requesters sharing a memory port, or multiple write-back sources sharing a register-file write port.
- Sustains one transfer per cycle.

Parameters:
- WIDTH, 32, data bits per channel.
- N_IN, 4, number of input channels (1..16; power of two not required).
- SEL_W, $clog2(N_IN) with minimum 1, width of the channel index (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_IN*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel request.
- in_ready  out  N_IN  per-channel accept. One-hot or zero.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds a transfer.
- out_ready  in  1  sink accepts the transfer.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is combinational and is 0 while out_valid=0 with no requests.
- load_en = !out_valid || out_ready (output register empty, or draining this cycle).
- Arbitration (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping from N_IN-1 to 0.
  - The first set bit wins (grant, one-hot).
  - in_ready = load_en ? grant : 0.
- Accept (same edge):
  - Condition: load_en and any in_valid.
  - out_data <= winner's data, out_sel <= winner index, out_valid <= 1.
  - ptr <= (winner+1) mod N_IN.
- Drain without refill (out_ready=1, no in_valid): out_valid <= 0. out_data and out_sel hold their last values. ptr holds.
- Stall (out_valid=1, out_ready=0): all in_ready=0; out_data, out_sel and ptr are stable; no input is lost.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 transfer/cycle with out_ready held high.
- No requests: no grant, ptr unchanged.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,N_IN-1,0. No channel waits more than N_IN-1 grants.
- Sink-side rules:
  - in_valid may drop before acceptance; no grant is latched across cycles.
  - out_ready may be asserted with out_valid=0; it has no effect.
- N_IN=1: pure registered pipeline stage; ptr constant 0; out_sel=0.
- Reset during a stall: the pending transfer is discarded (out_valid=0). Sources must re-present.
- No combinational path from out_ready to out_data or out_valid. The path out_ready -> in_ready is combinational (documented; accepted).

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input in_lock [N_IN].
  - If a granted channel is accepted with in_lock[i]=1, ptr <= i instead of i+1. The same channel keeps top priority for the next beat, giving atomic bursts (e.g. a read-modify-write or a multi-beat refill).
  - The lock releases on the first accepted beat from that channel with in_lock=0.
  - Reset clears the lock.
- Undefined: port absent; pure round-robin as above.

Decomposition:
- Package rr_arb_pkg:
  - function rr_pick(valid, ptr) returning the one-hot grant;
  - function onehot_to_idx;
  - localparam MAX_N_IN=16.
- Sub-module rr_arb_core: ptr register plus grant logic, N_IN-generic, reusable by other arbiters.
- The top level adds the data mux (AND-OR over one-hot grant) and the output register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset; first grant after release goes to channel 0.
- Round-robin: N_IN=4, in_data ch0..3 = 32'h0000_000A/B/C/D, all in_valid=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A.
- Back-pressure: out_ready=0 for 5 cycles after the first beat -> out_data=A stable, in_ready=0000; release -> next beat from ch1 one cycle later, no beat lost or duplicated.
- Sparse/wrap: ptr=3, only ch1 valid -> ch1 granted, ptr=2; then ch0 and ch2 valid -> ch2 granted first.
- Non-power-of-2: N_IN=3, WIDTH=5, inputs 5'h0F/5'h0A/5'h15, all valid -> out_sel 0,1,2,0 and out_data 0F,0A,15,0F; scoreboard checks every accepted beat emerges exactly once.
- Lock (RR_ARB_MUX_LOCK_EN): ch2 in_lock=1 for 3 beats with all valid -> out_sel 2,2,2,2 (lock released on the 4th beat), then 3,0.
